rvm_gprs_wb_arb: RTL and testbench

RVM_GPRS_WB_ARB -- requirements
Module: rvm_gprs_wb_arb

---
 rtl/rvm_gprs_wb_arb_pkg.sv | 24 ++
 rtl/rvm_arb_rr.sv | 64 ++++++
 rtl/rvm_gprs_wb_arb.sv | 150 +++++++++++++++
 tb/tb_rvm_gprs_wb_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvm_gprs_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// rvm_gprs_wb_arb_pkg
//   Shared constants for the GPR writeback path: register address width,
//   data width and register count, plus the staged-write record used by the
//   writeback arbiter.
//   No ports (package).
// ---------------------------------------------------------------------------
package rvm_gprs_wb_arb_pkg;

  localparam int RVM_REG_AW = 5;   // register address width
  localparam int RVM_DATA_W = 32;  // register data width
  localparam int RVM_NREGS  = 32;  // architectural register count

  typedef logic [RVM_REG_AW-1:0] reg_addr_t;
  typedef logic [RVM_DATA_W-1:0] reg_data_t;

  // One staged register-file write, presented the cycle after acceptance.
  typedef struct packed {
    logic      wen;
    reg_addr_t addr;
    reg_data_t wdata;
  } wb_stage_t;

endpackage

// File: rtl/rvm_arb_rr.sv
// ---------------------------------------------------------------------------
// rvm_arb_rr
//   Combinational writeback arbiter. Picks exactly one requester from req
//   (or none when req is all-zero) and returns it one-hot on gnt.
//   Configuration macro RVM_GPRS_ARB_RR_EN:
//     defined   - round-robin; search starts just after last_gnt, wrapping
//                 from NREQ-1 back to 0.
//     undefined - fixed priority, lowest index first; last_gnt is ignored.
//
//   Ports
//     req      in  [NREQ-1:0]  requesters holding a write
//     last_gnt in  [NREQ-1:0]  one-hot index of the most recent transfer
//     gnt      out [NREQ-1:0]  one-hot grant, or zero
// ---------------------------------------------------------------------------
module rvm_arb_rr #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last_gnt,
  output logic [NREQ-1:0] gnt
);

  // Requests the lowest-first priority encoder chooses from.
  logic [NREQ-1:0] pick;
  logic            taken;

`ifdef RVM_GPRS_ARB_RR_EN
  // after_last[i] is set for every index strictly above the last grant.
  // Requests in that window win first; if there are none the search wraps
  // and the plain lowest-index request wins.
  logic [NREQ-1:0] after_last;
  logic [NREQ-1:0] req_hi;

  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    after_last = '0;
    for (int i = 1; i < NREQ; i++) begin
      after_last[i] = after_last[i-1] | last_gnt[i-1];
    end
  end

  assign req_hi = req & after_last;
  assign pick   = (|req_hi) ? req_hi : req;
`else
  // Fixed priority: the grant history is still maintained by the parent
  // but plays no part in the decision here.
  logic unused_last_gnt;
  assign unused_last_gnt = ^last_gnt;
  assign pick            = req;
`endif

  always_comb begin
    gnt   = '0;
    taken = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i] && !taken) begin
        gnt[i] = 1'b1;
        taken  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvm_gprs_wb_arb.sv
// ---------------------------------------------------------------------------
// rvm_gprs_wb_arb
//   GPR writeback arbiter with pending-write scoreboard. Up to NREQ (2..4)
//   requesters compete for the single register-file write port. The
//   accepted write is registered and presented on rd_* one cycle later.
//   The scoreboard (busy) tracks registers with an outstanding write: the
//   issue stage sets a bit via sb_set, an accepted write clears it.
//   Configuration macro RVM_GPRS_ARB_RR_EN selects round-robin arbitration
//   (see rvm_arb_rr); the default build uses fixed priority.
//
//   Ports
//     clk        in   core clock, rising edge
//     resetn     in   asynchronous active-low reset
//     clk_req    out  block needs its clock this cycle
//     req_valid  in   [NREQ]      requester i holds a write
//     req_ready  out  [NREQ]      requester i accepted this cycle (one-hot)
//     req_addr   in   [5*NREQ]    destination of requester i at [5i+4:5i]
//     req_wdata  in   [32*NREQ]   data of requester i at [32i+31:32i]
//     sb_set     in   mark sb_addr pending
//     sb_addr    in   [5]  register to mark
//     flush      in   clear all marks, drop the write, block acceptance
//     busy       out  [32] pending-write scoreboard, bit 0 always 0
//     rd_wen     out  register-file write enable (single cycle)
//     rd_addr    out  [5]  register-file write address
//     rd_wdata   out  [32] register-file write data
// ---------------------------------------------------------------------------
module rvm_gprs_wb_arb
  import rvm_gprs_wb_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       clk_req,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [RVM_REG_AW*NREQ-1:0] req_addr,
  input  logic [RVM_DATA_W*NREQ-1:0] req_wdata,
  input  logic                       sb_set,
  input  logic [RVM_REG_AW-1:0]      sb_addr,
  input  logic                       flush,
  output logic [RVM_NREGS-1:0]       busy,
  output logic                       rd_wen,
  output logic [RVM_REG_AW-1:0]      rd_addr,
  output logic [RVM_DATA_W-1:0]      rd_wdata
);

  logic [NREQ-1:0]      last_gnt;
  logic [NREQ-1:0]      gnt;
  logic                 transfer;
  reg_addr_t            sel_addr;
  reg_data_t            sel_wdata;
  wb_stage_t            stage_q;
  logic [RVM_NREGS-1:0] busy_next;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  rvm_arb_rr #(
    .NREQ     (NREQ)
  ) u_arb (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Grants are masked during reset and on flush so nothing is accepted
  // while the staging path is being cleared.
  assign req_ready = gnt & {NREQ{resetn & ~flush}};
  assign transfer  = |(req_valid & req_ready);

  // req_ready is one-hot, so OR-ing the selected lanes yields the winner.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr  = sel_addr  | req_addr [RVM_REG_AW*i +: RVM_REG_AW];
        sel_wdata = sel_wdata | req_wdata[RVM_DATA_W*i +: RVM_DATA_W];
      end
    end
  end

  // Reset value points at the top requester so the first search, in either
  // arbitration mode, starts at requester 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt <= {1'b1, {(NREQ-1){1'b0}}};
    end else if (transfer) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the clock edge.
      last_gnt <= req_ready;
    end
  end

  // -------------------------------------------------------------------------
  // Write staging: one-cycle registered register-file port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: address and data are reset along with the enable because the
      // port must read as all zeros during reset, not merely be disabled.
      stage_q <= '0;
    end else begin
      // Register 0 is hard-wired: the handshake completes but no write.
      stage_q.wen <= transfer && (sel_addr != '0);
      if (transfer) begin
        stage_q.addr  <= sel_addr;
        stage_q.wdata <= sel_wdata;
      end
    end
  end

  assign rd_wen   = stage_q.wen;
  assign rd_addr  = stage_q.addr;
  assign rd_wdata = stage_q.wdata;

  // -------------------------------------------------------------------------
  // Pending-write scoreboard
  // -------------------------------------------------------------------------
  // Order encodes precedence: clear by accepted write, then set (set wins
  // on a same-address collision), then flush over everything.
  always_comb begin
    busy_next = busy;
    if (transfer) begin
      busy_next[sel_addr] = 1'b0;
    end
    if (sb_set) begin
      busy_next[sb_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Clock request: any pending input, output or scoreboard activity
  // -------------------------------------------------------------------------
  assign clk_req = (|req_valid) | sb_set | flush | rd_wen | (|busy);

endmodule

// File: tb/tb_rvm_gprs_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_rvm_gprs_wb_arb
//   Directed self-checking bench for rvm_gprs_wb_arb (NREQ = 3). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled a further
//   1 time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rvm_gprs_wb_arb;

  localparam int NREQ = 3;

  logic                 clk;
  logic                 resetn;
  logic                 clk_req;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0]   req_wdata;
  logic                 sb_set;
  logic [4:0]           sb_addr;
  logic                 flush;
  logic [31:0]          busy;
  logic                 rd_wen;
  logic [4:0]           rd_addr;
  logic [31:0]          rd_wdata;

  logic [4:0]           addr_v [NREQ];
  logic [31:0]          data_v [NREQ];

  int n_assert = 0;
  int n_fail   = 0;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr [5*i  +: 5]  = addr_v[i];
      req_wdata[32*i +: 32] = data_v[i];
    end
  end

  rvm_gprs_wb_arb #(
    .NREQ      (NREQ)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clk_req   (clk_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .flush     (flush),
    .busy      (busy),
    .rd_wen    (rd_wen),
    .rd_addr   (rd_addr),
    .rd_wdata  (rd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge to the drive point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    sb_set    = 1'b0;
    sb_addr   = '0;
    flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_v[i] = '0;
      data_v[i] = '0;
    end

    // ---- Reset state -------------------------------------------------------
    #2;
    check("rst_rd_wen",   rd_wen,    1'b0);
    check("rst_rd_addr",  rd_addr,   5'd0);
    check("rst_rd_wdata", rd_wdata,  32'h0);
    check("rst_busy",     busy,      32'h0);
    check("rst_clk_req_idle", clk_req, 1'b0);
    req_valid = 3'b111;
    #1;
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_clk_req_valid", clk_req, 1'b1);
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // ---- Two requesters held: grant 0 then 1, rd_* one cycle later --------
    addr_v[0] = 5'd5;  data_v[0] = 32'hA5A5_0001;
    addr_v[1] = 5'd6;  data_v[1] = 32'h5A5A_0002;
    req_valid = 3'b011;
    #1;
    check("t1_grant0", req_ready, 3'b001);
    check("t1_no_wen_yet", rd_wen, 1'b0);
    tick();
    req_valid = 3'b010;
    #1;
    check("t1_grant1", req_ready, 3'b010);
    check("t1_wen0",   rd_wen,    1'b1);
    check("t1_addr0",  rd_addr,   5'd5);
    check("t1_data0",  rd_wdata,  32'hA5A5_0001);
    tick();
    req_valid = 3'b000;
    #1;
    check("t1_wen1",  rd_wen,   1'b1);
    check("t1_addr1", rd_addr,  5'd6);
    check("t1_data1", rd_wdata, 32'h5A5A_0002);
    tick();
    check("t1_wen_drop", rd_wen, 1'b0);

    // ---- Scoreboard set then cleared by requester 2 -----------------------
    sb_set  = 1'b1;
    sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    check("t2_busy_set", busy, 32'h0000_0080);
    addr_v[2] = 5'd7;
    data_v[2] = 32'hDEAD_BEEF;
    req_valid = 3'b100;
    #1;
    check("t2_grant2", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    check("t2_busy_clr", busy,     32'h0);
    check("t2_wen",      rd_wen,   1'b1);
    check("t2_addr",     rd_addr,  5'd7);
    check("t2_data",     rd_wdata, 32'hDEAD_BEEF);

    // ---- Set and clear of the same register in one cycle: set wins --------
    addr_v[0] = 5'd9;
    data_v[0] = 32'h0000_0909;
    req_valid = 3'b001;
    sb_set    = 1'b1;
    sb_addr   = 5'd9;
    tick();
    sb_set = 1'b0;
    check("t3_busy_set_wins", busy,    32'h0000_0200);
    check("t3_wen",           rd_wen,  1'b1);
    check("t3_addr",          rd_addr, 5'd9);
    tick();
    req_valid = 3'b000;
    check("t3_busy_clr", busy, 32'h0);

    // ---- Write to register 0: handshake only ------------------------------
    addr_v[0] = 5'd0;
    data_v[0] = 32'h0000_0001;
    req_valid = 3'b001;
    #1;
    check("t4_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("t4_no_wen", rd_wen, 1'b0);
    check("t4_busy",   busy,   32'h0);

    // ---- Flush with busy = 0xF00 and requester 1 valid --------------------
    for (int a = 8; a < 12; a++) begin
      sb_set  = 1'b1;
      sb_addr = 5'(a);
      tick();
    end
    sb_set = 1'b0;
    check("t5_busy_pre", busy, 32'h0000_0F00);
    flush     = 1'b1;
    sb_set    = 1'b1;
    sb_addr   = 5'd3;
    addr_v[1] = 5'd12;
    data_v[1] = 32'h1212_1212;
    req_valid = 3'b010;
    #1;
    check("t5_ready_blocked", req_ready, 3'b000);
    check("t5_clk_req",       clk_req,   1'b1);
    tick();
    flush     = 1'b0;
    sb_set    = 1'b0;
    req_valid = 3'b000;
    check("t5_busy_flushed", busy,   32'h0);
    check("t5_no_wen",       rd_wen, 1'b0);

    // ---- Reset pulsed mid-transfer ----------------------------------------
    addr_v[0] = 5'd4;
    data_v[0] = 32'h0000_0055;
    req_valid = 3'b001;
    sb_set    = 1'b1;
    sb_addr   = 5'd5;
    tick();
    sb_set = 1'b0;
    check("t6_pre_wen",  rd_wen, 1'b1);
    check("t6_pre_busy", busy,   32'h0000_0020);
    req_valid = 3'b111;
    addr_v[1] = 5'd13;
    addr_v[2] = 5'd14;
    #1;
    resetn = 1'b0;
    #1;
    check("t6_rst_wen",   rd_wen,    1'b0);
    check("t6_rst_addr",  rd_addr,   5'd0);
    check("t6_rst_data",  rd_wdata,  32'h0);
    check("t6_rst_busy",  busy,      32'h0);
    check("t6_rst_ready", req_ready, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("t6_first_grant", req_ready, 3'b001);

    // ---- All requesters held after reset: grant sequence ------------------
    tick();
    check("t7_wen", rd_wen, 1'b1);
`ifdef RVM_GPRS_ARB_RR_EN
    check("t7_rr_grant1", req_ready, 3'b010);
    tick();
    check("t7_rr_grant2", req_ready, 3'b100);
    tick();
    check("t7_rr_wrap",   req_ready, 3'b001);
`else
    check("t7_fp_grant0a", req_ready, 3'b001);
    tick();
    check("t7_fp_grant0b", req_ready, 3'b001);
    tick();
    check("t7_fp_grant0c", req_ready, 3'b001);
`endif
    req_valid = 3'b000;
    tick();
    check("t7_idle_wen",     rd_wen,  1'b0);
    check("t7_idle_clk_req", clk_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
